// File: rtl/apu_frame_sequencer_pkg.sv
// Shared APU frame-sequencer definitions: NTSC step counts, mode encoding, FSM states.
package apu_pkg;

    localparam int unsigned CW          = 16;
    localparam int unsigned DW          = 2;
    localparam int unsigned WRITE_DELAY = 3;

    localparam logic [CW-1:0] Q1 = 16'd7457;
    localparam logic [CW-1:0] Q2 = 16'd14913;
    localparam logic [CW-1:0] Q3 = 16'd22371;
    localparam logic [CW-1:0] Q4 = 16'd29829;
    localparam logic [CW-1:0] Q5 = 16'd37281;

    // IRQ is raised over the last two counts of a 4-step period
    localparam logic [CW-1:0] IRQ_ARM = Q4 - 16'd1;

    localparam logic MODE_4STEP = 1'b0;
    localparam logic MODE_5STEP = 1'b1;

    typedef logic [0:0] fsmState_t;
    localparam fsmState_t RUN     = 1'b0;
    localparam fsmState_t PENDING = 1'b1;

endpackage

// File: rtl/apu_frame_sequencer_if.sv
// CPU-side register strobes and frame-clock enables of the APU frame sequencer.
interface apu_frame_sequencer_if;

    logic       reg_wr;
    logic [7:0] reg_data;
    logic       status_rd;
    logic       quarter_frame;
    logic       half_frame;
    logic       frame_irq;
    logic       mode;

    modport master (
        output reg_wr, reg_data, status_rd,
        input  quarter_frame, half_frame, frame_irq, mode
    );

    modport slave (
        input  reg_wr, reg_data, status_rd,
        output quarter_frame, half_frame, frame_irq, mode
    );

endinterface

// File: rtl/apu_frame_sequencer.sv
// Frame counter producing quarter/half-frame enable pulses and the frame IRQ,
// with the delayed restart that follows a $4017 write.
module apu_frame_sequencer
    import apu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    apu_frame_sequencer_if.slave   bus
);

    logic [CW-1:0] count,    countNext;
    logic          modeQ,    modeNext;
    logic          inhibit,  inhibitNext;
    logic          irq,      irqNext;
    logic          quarter,  quarterNext;
    logic          half,     halfNext;
    fsmState_t     state,    stateNext;
    logic [DW-1:0] delay,    delayNext;
    logic          pendMode, pendModeNext;

    logic [CW-1:0] wrapCnt;
    logic          restart;
    logic          unusedData;

    // Only mode and inhibit bits of $4017 are meaningful here
    assign unusedData = ^bus.reg_data[5:0];

    always_comb begin
        stateNext    = state;
        delayNext    = delay;
        pendModeNext = pendMode;
        countNext    = count;
        modeNext     = modeQ;
        inhibitNext  = inhibit;
        irqNext      = irq;
        quarterNext  = 1'b0;
        halfNext     = 1'b0;

        wrapCnt = (modeQ == MODE_5STEP) ? Q5 : Q4;
        restart = (state == PENDING) && (delay == DW'(0)) && !bus.reg_wr;

        // Restart overrides any coinciding step match; 5-step gives an immediate clock
        if (restart) begin
            countNext   = '0;
            modeNext    = pendMode;
            quarterNext = (pendMode == MODE_5STEP);
            halfNext    = (pendMode == MODE_5STEP);
            stateNext   = RUN;
        end else begin
            countNext   = (count == wrapCnt) ? '0 : count + CW'(1);
            quarterNext = (count == Q1) || (count == Q2) || (count == Q3) || (count == wrapCnt);
            halfNext    = (count == Q2) || (count == wrapCnt);
        end

        // Any write (re)starts the delay; the last write before expiry wins
        if (bus.reg_wr) begin
            pendModeNext = bus.reg_data[7];
            inhibitNext  = bus.reg_data[6];
            delayNext    = DW'(WRITE_DELAY - 1);
            stateNext    = PENDING;
        end else if ((state == PENDING) && (delay != DW'(0))) begin
            delayNext = delay - DW'(1);
        end

        if (bus.status_rd || (bus.reg_wr && bus.reg_data[6])) begin
            irqNext = 1'b0;
        end
        if ((modeQ == MODE_4STEP) && !inhibit && ((count == IRQ_ARM) || (count == Q4))) begin
            irqNext = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            delay    <= '0;
            pendMode <= MODE_4STEP;
            count    <= '0;
            modeQ    <= MODE_4STEP;
            inhibit  <= 1'b0;
            irq      <= 1'b0;
            quarter  <= 1'b0;
            half     <= 1'b0;
        end else begin
            state    <= stateNext;
            delay    <= delayNext;
            pendMode <= pendModeNext;
            count    <= countNext;
            modeQ    <= modeNext;
            inhibit  <= inhibitNext;
            irq      <= irqNext;
            quarter  <= quarterNext;
            half     <= halfNext;
        end
    end

    assign bus.quarter_frame = quarter;
    assign bus.half_frame    = half;
    assign bus.frame_irq     = irq;
    assign bus.mode          = modeQ;

endmodule
